// File: rtl/pipelined_barrel_shifter.sv
// Pipelined ROR/ROL/LSR/ASR barrel shifter, one log2 level per stage; latency LOG2W cycles, one result per cycle.
// Backpressure: a stalled output freezes every stage (bubbles included) and drops inReady in the same cycle.
module pipelined_barrel_shifter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    localparam int LOG2W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inData,
    input  logic [LOG2W-1:0] shiftAmount,
    input  logic [1:0]       mode,
    input  logic [TAG_W-1:0] inTag,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData,
    output logic [TAG_W-1:0] outTag,
    output logic             busy
);

    localparam logic [1:0] MODE_ROR = 2'b00;
    localparam logic [1:0] MODE_ROL = 2'b01;
    localparam logic [1:0] MODE_LSR = 2'b10;

    logic             advance;

    logic [LOG2W-1:0] st_vld;
    logic [WIDTH-1:0] st_dat  [LOG2W];
    logic [LOG2W-1:0] st_amt  [LOG2W];
    logic [1:0]       st_mode [LOG2W];
    logic [TAG_W-1:0] st_tag  [LOG2W];

    logic [LOG2W-1:0] nxt_vld;
    logic [WIDTH-1:0] nxt_dat  [LOG2W];
    logic [LOG2W-1:0] nxt_amt  [LOG2W];
    logic [1:0]       nxt_mode [LOG2W];
    logic [TAG_W-1:0] nxt_tag  [LOG2W];

    assign advance = !outValid || outReady;
    assign inReady = advance;

    for (genvar k = 0; k < LOG2W; k++) begin : g_stage
        localparam int DIST = 1 << k;

        logic [WIDTH-1:0] src;
        logic [LOG2W-1:0] src_amt;
        logic [1:0]       src_mode;
        logic [TAG_W-1:0] src_tag;
        logic             src_vld;
        logic             src_sel;
        logic [WIDTH-1:0] shifted;

        if (k == 0) begin : g_head
            assign src      = inData;
            assign src_amt  = shiftAmount;
            assign src_mode = mode;
            assign src_tag  = inTag;
            assign src_vld  = inValid;
            assign src_sel  = shiftAmount[k];
        end else begin : g_body
            assign src      = st_dat[k-1];
            assign src_amt  = st_amt[k-1];
            assign src_mode = st_mode[k-1];
            assign src_tag  = st_tag[k-1];
            assign src_vld  = st_vld[k-1];
            assign src_sel  = st_amt[k-1][k];
        end

        // ASR: the running MSB is still the operand's sign, so each level replicates its own MSB.
        always_comb begin
            shifted = src;
            case (src_mode)
                MODE_ROR: shifted = (src >> DIST) | (src << (WIDTH - DIST));
                MODE_ROL: shifted = (src << DIST) | (src >> (WIDTH - DIST));
                MODE_LSR: shifted = src >> DIST;
                default:  shifted = $signed(src) >>> DIST;
            endcase
        end

        assign nxt_dat[k]  = src_sel ? shifted : src;
        assign nxt_amt[k]  = src_amt;
        assign nxt_mode[k] = src_mode;
        assign nxt_tag[k]  = src_tag;
        assign nxt_vld[k]  = src_vld;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_vld <= '0;
            for (int k = 0; k < LOG2W; k++) begin
                st_dat[k]  <= '0;
                st_amt[k]  <= '0;
                st_mode[k] <= '0;
                st_tag[k]  <= '0;
            end
        end else if (advance) begin
            st_vld <= nxt_vld;
            for (int k = 0; k < LOG2W; k++) begin
                st_dat[k]  <= nxt_dat[k];
                st_amt[k]  <= nxt_amt[k];
                st_mode[k] <= nxt_mode[k];
                st_tag[k]  <= nxt_tag[k];
            end
        end
    end

    assign outValid = st_vld[LOG2W-1];
    assign outData  = st_dat[LOG2W-1];
    assign outTag   = st_tag[LOG2W-1];
    assign busy     = |st_vld;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed + random bench for pipelined_barrel_shifter at WIDTH=8, with a queue-based reference scoreboard.
module tb_pipelined_barrel_shifter;

    localparam int W  = 8;
    localparam int TW = 4;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          inValid;
    logic          inReady;
    logic [W-1:0]  inData;
    logic [LW-1:0] shiftAmount;
    logic [1:0]    mode;
    logic [TW-1:0] inTag;
    logic          outValid;
    logic          outReady;
    logic [W-1:0]  outData;
    logic [TW-1:0] outTag;
    logic          busy;

    pipelined_barrel_shifter #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset),
        .inValid(inValid), .inReady(inReady), .inData(inData),
        .shiftAmount(shiftAmount), .mode(mode), .inTag(inTag),
        .outValid(outValid), .outReady(outReady), .outData(outData),
        .outTag(outTag), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  d;
        logic [TW-1:0] t;
        int            c;
    } exp_t;

    exp_t          q[$];
    int            n_assert = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            last_lat = -1;
    logic          prev_stall = 1'b0;
    logic [W-1:0]  prev_dat;
    logic [TW-1:0] prev_tag;
    logic [W-1:0]  frz_dat;
    logic [TW-1:0] frz_tag;
    logic [11:0]   hist;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit-by-bit definition of each mode, independent of any log2 decomposition.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int a, input logic [1:0] m);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            case (m)
                2'b00:   r[i] = d[(i + a) % W];
                2'b01:   r[i] = d[(i - a + W) % W];
                2'b10:   r[i] = (i + a < W) ? d[i + a] : 1'b0;
                default: r[i] = (i + a < W) ? d[i + a] : d[W-1];
            endcase
        end
        return r;
    endfunction

    task automatic step();
        exp_t e;
        @(negedge clk);
        if (reset) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_vld", 32'(outValid), 32'd1);
                check("hold_dat", 32'(outData), 32'(prev_dat));
                check("hold_tag", 32'(outTag), 32'(prev_tag));
            end
            check("inready_rule", 32'(inReady), 32'(!outValid || outReady));
            if (outValid) begin
                check("no_spurious", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0 && outReady) begin
                    e = q.pop_front();
                    check("sb_data", 32'(outData), 32'(e.d));
                    check("sb_tag", 32'(outTag), 32'(e.t));
                    last_lat = cyc - e.c;
                end
            end
            if (inValid && inReady) begin
                e.d = ref_shift(inData, int'(shiftAmount), mode);
                e.t = inTag;
                e.c = cyc;
                q.push_back(e);
            end
            prev_stall = outValid && !outReady;
            prev_dat   = outData;
            prev_tag   = outTag;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rand_in();
        inData      = W'($urandom);
        shiftAmount = LW'($urandom_range(0, W - 1));
        mode        = 2'($urandom_range(0, 3));
        inTag       = TW'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic run_single(input logic [W-1:0] d, input logic [LW-1:0] a, input logic [1:0] m,
                              input logic [TW-1:0] t, input logic [W-1:0] exp, input string tag);
        inValid = 1'b1; inData = d; shiftAmount = a; mode = m; inTag = t; outReady = 1'b1;
        step();
        inValid = 1'b0;
        step();
        step();
        check({tag, "_vld"}, 32'(outValid), 32'd1);
        check({tag, "_dat"}, 32'(outData), 32'(exp));
        check({tag, "_tag"}, 32'(outTag), 32'(t));
        step();
        check({tag, "_lat"}, 32'(last_lat), 32'd3);
    endtask

    initial begin
        reset = 1'b1; inValid = 1'b0; outReady = 1'b1;
        inData = '0; shiftAmount = '0; mode = '0; inTag = '0;
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_outvalid", 32'(outValid), 32'd0);
        check("rst_outdata", 32'(outData), 32'd0);
        check("rst_outtag", 32'(outTag), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_inready", 32'(inReady), 32'd1);

        run_single(8'hB1, 3'd3, 2'b00, 4'h1, 8'h36, "b1_ror3");
        run_single(8'hB1, 3'd3, 2'b01, 4'h2, 8'h8D, "b1_rol3");
        run_single(8'hB1, 3'd3, 2'b10, 4'h3, 8'h16, "b1_lsr3");
        run_single(8'hB1, 3'd3, 2'b11, 4'h4, 8'hF6, "b1_asr3");
        for (int m = 0; m < 4; m++)
            run_single(8'h80, 3'd0, 2'(m), 4'(m + 5), 8'h80, "s0_80");
        run_single(8'h80, 3'd7, 2'b00, 4'h9, 8'h01, "s7_ror");
        run_single(8'h80, 3'd7, 2'b01, 4'hA, 8'h40, "s7_rol");
        run_single(8'h80, 3'd7, 2'b10, 4'hB, 8'h01, "s7_lsr");
        run_single(8'h80, 3'd7, 2'b11, 4'hC, 8'hFF, "s7_asr");

        // 16 back-to-back beats: outputs in cycles 3..18, busy in 1..18.
        outReady = 1'b1;
        for (int t = 0; t < 20; t++) begin
            check("b2b_busy", 32'(busy), 32'(t >= 1 && t <= 18));
            check("b2b_outvalid", 32'(outValid), 32'(t >= 3 && t <= 18));
            inValid = (t < 16);
            rand_in();
            step();
        end
        drain();

        // Fill, then stall 5 cycles while offering more input.
        inValid = 1'b1;
        for (int t = 0; t < 3; t++) begin
            rand_in();
            step();
        end
        frz_dat = outData;
        frz_tag = outTag;
        check("bp_full", 32'(outValid), 32'd1);
        for (int t = 0; t < 5; t++) begin
            outReady = 1'b0;
            rand_in();
            #2;
            check("bp_inready", 32'(inReady), 32'd0);
            check("bp_frz_dat", 32'(outData), 32'(frz_dat));
            check("bp_frz_tag", 32'(outTag), 32'(frz_tag));
            step();
        end
        outReady = 1'b1;
        inValid  = 1'b0;
        drain();

        // Bubbles with outReady held high: gaps reappear 3 cycles later.
        hist = '0;
        for (int t = 0; t < 12; t++) begin
            check("bubble_gap", 32'(outValid), 32'((t >= 3) ? hist[t-3] : 1'b0));
            inValid = (t < 8) && (t % 2 == 0);
            hist[t] = inValid;
            rand_in();
            step();
        end
        // Bubbles with random backpressure, checked by the scoreboard.
        for (int t = 0; t < 24; t++) begin
            inValid  = (t % 2 == 0);
            outReady = 1'($urandom_range(0, 1));
            rand_in();
            step();
        end
        outReady = 1'b1;
        inValid  = 1'b0;
        drain();

        // Reset with 3 beats in flight and a new beat offered.
        inValid = 1'b1;
        for (int t = 0; t < 3; t++) begin
            rand_in();
            step();
        end
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        rand_in();
        step();
        reset   = 1'b0;
        inValid = 1'b0;
        #1;
        check("mid_rst_outvalid", 32'(outValid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_outdata", 32'(outData), 32'd0);
        check("mid_rst_inready", 32'(inReady), 32'd1);
        for (int t = 0; t < 5; t++) begin
            check("post_rst_quiet", 32'(outValid), 32'd0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
